// File: rtl/arb_req_frontend_if.sv
// Handshake bundle between the request frontend (slave) and its upstream feeder/arbiter side (master).
interface arb_req_frontend_if #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 4
);
    logic             push_0;
    logic             push_1;
    logic [LEN_W-1:0] cfg_len_0;
    logic [LEN_W-1:0] cfg_len_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             req_0;
    logic             req_1;
    logic             busy_0;
    logic             busy_1;
    logic             done_0;
    logic             done_1;
    logic [CNT_W-1:0] pend_0;
    logic [CNT_W-1:0] pend_1;
    logic             full_0;
    logic             full_1;
    logic             drop_0;
    logic             drop_1;
    logic             timeout_0;
    logic             timeout_1;
    logic             err;

    modport master (
        output push_0, push_1, cfg_len_0, cfg_len_1, gnt_0, gnt_1,
        input  req_0, req_1, busy_0, busy_1, done_0, done_1, pend_0, pend_1,
        input  full_0, full_1, drop_0, drop_1, timeout_0, timeout_1, err
    );

    modport slave (
        input  push_0, push_1, cfg_len_0, cfg_len_1, gnt_0, gnt_1,
        output req_0, req_1, busy_0, busy_1, done_0, done_1, pend_0, pend_1,
        output full_0, full_1, drop_0, drop_1, timeout_0, timeout_1, err
    );
endinterface

// File: rtl/arb_req_frontend.sv
// Two-channel job queue + request/burst FSM feeding the req/gnt arbiter, with sticky grant-protocol error flag.
// Optional macro REQ_TIMEOUT_EN adds a per-channel REQ wait timeout that discards the waiting job.
module arb_req_frontend #(
    parameter int CNT_W   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 32
) (
    input logic               clock,
    input logic               reset,
    arb_req_frontend_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    // A zero-length config still transfers one beat.
    function automatic logic [LEN_W-1:0] last_beat(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

    state_t           state_q [2];
    state_t           state_d [2];
    logic [LEN_W-1:0] beat_q  [2];
    logic [LEN_W-1:0] beat_d  [2];
    logic [CNT_W-1:0] pend_q  [2];
    logic [CNT_W-1:0] pend_d  [2];
    logic [LEN_W-1:0] cfg_len [2];
    logic [1:0]       push, gnt, req_q, busy, done, full, drop, dec, inc, tmo;
    logic             err_q, err_d;

    assign push       = {bus.push_1, bus.push_0};
    assign gnt        = {bus.gnt_1, bus.gnt_0};
    assign cfg_len[0] = bus.cfg_len_0;
    assign cfg_len[1] = bus.cfg_len_1;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("TIMEOUT must be at least 1");
    end

`ifdef REQ_TIMEOUT_EN
    localparam int              WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q [2];
    logic [WAIT_W-1:0] wait_d [2];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            tmo[c]    = (state_q[c] == REQ) && !gnt[c] && (wait_q[c] == WAIT_LAST);
            wait_d[c] = ((state_q[c] == REQ) && !gnt[c]) ? wait_q[c] + WAIT_W'(1) : '0;
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (reset) wait_q[c] <= '0;
            else       wait_q[c] <= wait_d[c];
        end
    end
`else
    assign tmo = '0;
`endif

    always_comb begin
        err_d = err_q | (gnt[0] & gnt[1]);
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            beat_d[c]  = beat_q[c];
            dec[c]     = 1'b0;
            busy[c]    = 1'b0;
            done[c]    = 1'b0;
            case (state_q[c])
                IDLE: if (pend_q[c] != '0) state_d[c] = REQ;
                REQ: begin
                    if (gnt[c]) begin
                        state_d[c] = XFER;
                        beat_d[c]  = last_beat(cfg_len[c]);
                        dec[c]     = 1'b1;
                    end else if (tmo[c]) begin
                        state_d[c] = IDLE;
                        dec[c]     = 1'b1;
                    end
                end
                XFER: begin
                    busy[c] = 1'b1;
                    if (beat_q[c] == '0) begin
                        done[c]    = 1'b1;
                        state_d[c] = IDLE;
                    end else begin
                        beat_d[c] = beat_q[c] - LEN_W'(1);
                    end
                end
                default: state_d[c] = IDLE;
            endcase

            // A push at full is still accepted when a job leaves on the same edge.
            full[c]   = (pend_q[c] == PEND_MAX);
            inc[c]    = push[c] && (!full[c] || dec[c]);
            drop[c]   = push[c] && full[c] && !dec[c];
            pend_d[c] = pend_q[c];
            if (inc[c] && !dec[c])      pend_d[c] = pend_q[c] + CNT_W'(1);
            else if (dec[c] && !inc[c]) pend_d[c] = pend_q[c] - CNT_W'(1);

            err_d = err_d | (gnt[c] && (state_q[c] == IDLE)) | (!gnt[c] && (state_q[c] == XFER));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                beat_q[c]  <= '0;
                pend_q[c]  <= '0;
            end
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                beat_q[c]  <= beat_d[c];
                pend_q[c]  <= pend_d[c];
                req_q[c]   <= (state_d[c] != IDLE);
            end
            err_q <= err_d;
        end
    end

    assign bus.req_0     = req_q[0];
    assign bus.req_1     = req_q[1];
    assign bus.busy_0    = busy[0];
    assign bus.busy_1    = busy[1];
    assign bus.done_0    = done[0];
    assign bus.done_1    = done[1];
    assign bus.pend_0    = pend_q[0];
    assign bus.pend_1    = pend_q[1];
    assign bus.full_0    = full[0];
    assign bus.full_1    = full[1];
    assign bus.drop_0    = drop[0];
    assign bus.drop_1    = drop[1];
    assign bus.timeout_0 = tmo[0];
    assign bus.timeout_1 = tmo[1];
    assign bus.err       = err_q;
endmodule

// File: tb/tb_arb_req_frontend.sv
// Bench for arb_req_frontend: directed table, hand-written corner sequences and random traffic vs. a job/burst model.
module tb_arb_req_frontend;
    localparam int CNT_W = 4;
    localparam int LEN_W = 4;
    localparam int TMO   = 32;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    arb_req_frontend_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    arb_req_frontend #(.CNT_W(CNT_W), .LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic             push0;
        logic [LEN_W-1:0] len0;
        logic             gnt0;
        logic             req0;
        logic             busy0;
        logic             done0;
        logic [CNT_W-1:0] pend0;
        logic             err;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: pending jobs, remaining busy beats, whether the channel is asking, cycles spent waiting.
    int m_pend [2];
    int m_left [2];
    int m_wait [2];
    bit m_req  [2];
    bit m_err;

    bit t_push [2];
    int t_len  [2];
    bit t_gnt  [2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit p0, input bit p1, input int l0, input int l1, input bit g0, input bit g1);
        t_push[0] = p0; t_push[1] = p1;
        t_len[0]  = l0; t_len[1]  = l1;
        t_gnt[0]  = g0; t_gnt[1]  = g1;
        bus.push_0    = p0;
        bus.push_1    = p1;
        bus.cfg_len_0 = LEN_W'(l0);
        bus.cfg_len_1 = LEN_W'(l1);
        bus.gnt_0     = g0;
        bus.gnt_1     = g1;
    endtask

    function automatic bit m_waiting(input int c);
        return m_req[c] && (m_left[c] == 0);
    endfunction

    function automatic bit m_tmo(input int c);
`ifdef REQ_TIMEOUT_EN
        return m_waiting(c) && !t_gnt[c] && (m_wait[c] == TMO - 1);
`else
        return m_waiting(c) && 1'b0;
`endif
    endfunction

    function automatic bit m_dec(input int c);
        return m_waiting(c) && (t_gnt[c] || m_tmo(c));
    endfunction

    function automatic logic [20:0] model_out();
        logic [1:0] rq, bs, dn, fl, dr, to;
        for (int c = 0; c < 2; c++) begin
            rq[c] = m_req[c];
            bs[c] = (m_left[c] > 0);
            dn[c] = (m_left[c] == 1);
            fl[c] = (m_pend[c] == PMAX);
            dr[c] = t_push[c] && fl[c] && !m_dec(c);
            to[c] = m_tmo(c);
        end
        return {rq, bs, dn, fl, dr, to, m_err, CNT_W'(m_pend[1]), CNT_W'(m_pend[0])};
    endfunction

    function automatic logic [20:0] dut_out();
        return {bus.req_1, bus.req_0, bus.busy_1, bus.busy_0, bus.done_1, bus.done_0,
                bus.full_1, bus.full_0, bus.drop_1, bus.drop_0, bus.timeout_1, bus.timeout_0,
                bus.err, bus.pend_1, bus.pend_0};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0; m_left[c] = 0; m_wait[c] = 0; m_req[c] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit err_now;
        err_now = m_err || (t_gnt[0] && t_gnt[1]);
        for (int c = 0; c < 2; c++) begin
            bit dec, tmo, full;
            int old_pend;
            dec      = m_dec(c);
            tmo      = m_tmo(c);
            full     = (m_pend[c] == PMAX);
            old_pend = m_pend[c];
            err_now  = err_now || (t_gnt[c] && !m_req[c]) || (!t_gnt[c] && (m_left[c] > 0));
            if (t_push[c] && (!full || dec)) m_pend[c]++;
            if (dec) m_pend[c]--;
            if (m_left[c] > 0) begin
                m_left[c]--;
                if (m_left[c] == 0) m_req[c] = 1'b0;
            end else if (m_req[c]) begin
                if (t_gnt[c])  m_left[c] = (t_len[c] == 0) ? 1 : t_len[c];
                else if (tmo)  m_req[c]  = 1'b0;
                else           m_wait[c]++;
            end else if (old_pend > 0) begin
                m_req[c]  = 1'b1;
                m_wait[c] = 0;
            end
        end
        m_err = err_now;
    endtask

    task automatic cyc_begin(input string name, input bit p0, input bit p1, input int l0, input int l1,
                             input bit g0, input bit g1);
        drive(p0, p1, l0, l1, g0, g1);
        @(negedge clock);
        cmp(name, 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic cyc_end();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input string name, input bit p0, input bit p1, input int l0, input int l1,
                       input bit g0, input bit g1);
        cyc_begin(name, p0, p1, l0, l1, g0, g1);
        cyc_end();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input bit p, input int l, input bit g, input bit rq, input bit bs,
                                input bit dn, input int pd, input bit e);
        vec_t v;
        v.push0 = p; v.len0 = LEN_W'(l); v.gnt0 = g;
        v.req0 = rq; v.busy0 = bs; v.done0 = dn; v.pend0 = CNT_W'(pd); v.err = e;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   ndone, nbusy, owner, first, r_rise, t_seen;
        bit   g0, g1;

        // push 0 with length 3; grant two cycles after req rises, held while req is high
        tbl[0] = mk(1, 3, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 3, 0, 0, 0, 0, 1, 0);
        tbl[2] = mk(0, 3, 0, 1, 0, 0, 1, 0);
        tbl[3] = mk(0, 3, 0, 1, 0, 0, 1, 0);
        tbl[4] = mk(0, 3, 1, 1, 0, 0, 1, 0);
        tbl[5] = mk(0, 3, 1, 1, 1, 0, 0, 0);
        tbl[6] = mk(0, 3, 1, 1, 1, 0, 0, 0);
        tbl[7] = mk(0, 3, 1, 1, 1, 1, 0, 0);
        tbl[8] = mk(0, 3, 0, 0, 0, 0, 0, 0);
        tbl[9] = mk(0, 3, 0, 0, 0, 0, 0, 0);

        model_reset();
        do_reset();
        repeat (20) cyc("idle", 0, 0, 0, 0, 0, 0);
        cmp("idle_all_zero", 32'(dut_out()), 32'd0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc_begin("tbl_model", tbl[i].push0, 1'b0, int'(tbl[i].len0), 0, tbl[i].gnt0, 1'b0);
            cmp($sformatf("tbl_row%0d", i),
                32'({bus.req_0, bus.busy_0, bus.done_0, bus.pend_0, bus.err}),
                32'({tbl[i].req0, tbl[i].busy0, tbl[i].done0, tbl[i].pend0, tbl[i].err}));
            cyc_end();
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc_begin("fill", 1, 0, 0, 0, 0, 0);
            if (i == 15) cmp("full_drop", 32'({bus.pend_0, bus.full_0, bus.drop_0}), 32'({4'd15, 1'b1, 1'b1}));
            cyc_end();
        end
        cyc_begin("after_full", 0, 0, 0, 0, 0, 0);
        cmp("pend_hold15", 32'(bus.pend_0), 32'd15);
        cyc_end();

        do_reset();
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            cyc_begin("len0", 0, (i < 2), 0, 0, 0, 1);
            ndone += int'(bus.done_1);
            cyc_end();
        end
        cmp("len0_done_count", 32'(ndone), 32'd2);
        cmp("len0_pend_end", 32'(bus.pend_1), 32'd0);

        do_reset();
        cyc("both_gnt", 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc_begin("err_both_hold", 0, 0, 0, 0, 0, 0);
            cmp("err_both", 32'(bus.err), 32'd1);
            cyc_end();
        end

        do_reset();
        cyc("idle_gnt", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc_begin("err_idle_hold", 0, 0, 0, 0, 0, 0);
            cmp("err_idle_gnt", 32'(bus.err), 32'd1);
            cyc_end();
        end

        // grant dropped on the second of four beats; burst must still run to completion
        do_reset();
        nbusy = 0;
        for (int i = 0; i < 14; i++) begin
            g0 = m_req[0] && (m_left[0] != 3);
            cyc_begin("mid_drop", (i == 0), 0, 4, 0, g0, 0);
            nbusy += int'(bus.busy_0);
            cyc_end();
        end
        cmp("mid_drop_busy_len", 32'(nbusy), 32'd4);
        cmp("mid_drop_err", 32'(bus.err), 32'd1);

        // well-behaved arbiter: one owner at a time, held until req drops
        do_reset();
        owner = -1;
        for (int i = 0; i < 3000; i++) begin
            if (owner >= 0 && !m_req[owner]) owner = -1;
            if (owner < 0) begin
                first = int'($urandom_range(0, 1));
                for (int k = 0; k < 2; k++) begin
                    if (owner < 0 && m_req[(first + k) % 2] && $urandom_range(0, 1) == 1)
                        owner = (first + k) % 2;
                end
            end
            g0 = (owner == 0);
            g1 = (owner == 1);
            cyc("rand_arb", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), g0, g1);
        end

        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc("rand_any", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

`ifdef REQ_TIMEOUT_EN
        do_reset();
        r_rise = -1;
        t_seen = -1;
        for (int i = 0; i < 60; i++) begin
            cyc_begin("timeout", (i == 0), 0, 0, 0, 0, 0);
            if (r_rise < 0 && bus.req_0) r_rise = i;
            if (t_seen < 0 && bus.timeout_0) begin
                t_seen = i;
                cmp("timeout_pend_before", 32'(bus.pend_0), 32'd1);
            end
            cyc_end();
            if (t_seen == i) begin
                cmp("timeout_req_drop", 32'(bus.req_0), 32'd0);
                cmp("timeout_pend_after", 32'(bus.pend_0), 32'd0);
            end
        end
        cmp("timeout_latency", 32'(t_seen - r_rise), 32'(TMO - 1));
`else
        r_rise = 0;
        t_seen = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
